// File: rtl/vending_pkg.sv
// Shared vending-machine constants: coin values, dispenser state encoding
// and refill select codes.
package vending_pkg;

    localparam int COIN_ONE  = 1;
    localparam int COIN_TWO  = 2;
    localparam int COIN_FIVE = 5;
    localparam int MONEY_PAY = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } disp_state_t;

    typedef enum logic [1:0] {
        REFILL_ONE  = 2'd0,
        REFILL_TWO  = 2'd1,
        REFILL_FIVE = 2'd2,
        REFILL_NONE = 2'd3
    } refill_sel_t;

endpackage

// File: rtl/change_planner.sv
// Combinational greedy 5/2/1 change plan against the current coin stock.
// Greedy only: some payable amounts (e.g. 6 with no ones) report infeasible.
module change_planner #(
    parameter int AMT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic [AMT_W-1:0] i_amount,
    input  logic [CNT_W-1:0] i_stock_one,
    input  logic [CNT_W-1:0] i_stock_two,
    input  logic [CNT_W-1:0] i_stock_five,
    output logic [AMT_W-1:0] o_n5,
    output logic [AMT_W-1:0] o_n2,
    output logic [AMT_W-1:0] o_n1,
    output logic             o_feasible
);
    import vending_pkg::*;

    localparam logic [AMT_W-1:0] C5 = AMT_W'(COIN_FIVE);
    localparam logic [AMT_W-1:0] C2 = AMT_W'(COIN_TWO);

    logic [AMT_W-1:0] w_q5;
    logic [AMT_W-1:0] w_q2;
    logic [AMT_W-1:0] w_rem;

    // Stock is only truncated to AMT_W when it is below the quotient.
    always_comb begin
        w_q5       = i_amount / C5;
        o_n5       = (CNT_W'(w_q5) > i_stock_five) ? AMT_W'(i_stock_five) : w_q5;
        w_rem      = i_amount - o_n5 * C5;
        w_q2       = w_rem / C2;
        o_n2       = (CNT_W'(w_q2) > i_stock_two) ? AMT_W'(i_stock_two) : w_q2;
        o_n1       = w_rem - o_n2 * C2;
        o_feasible = (CNT_W'(o_n1) <= i_stock_one);
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: plans a greedy coin breakdown, then drives the hopper one
// coin at a time over a level/ack handshake, tracking per-denomination stock.
//
// state | meaning
// IDLE  | waiting for a request; refills accepted
// CHECK | planner evaluates latched amount against stock
// ISSUE | one coin command held until hopper ack
// GAP   | all coin commands low for one cycle between coins
// DONE  | one-cycle completion pulse
// ERR   | one-cycle "cannot make change" pulse
module change_dispenser #(
    parameter int               AMT_W     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [CNT_W-1:0] INIT_ONE  = 8,
    parameter logic [CNT_W-1:0] INIT_TWO  = 8,
    parameter logic [CNT_W-1:0] INIT_FIVE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [AMT_W-1:0] i_amount,
    output logic             o_busy,
    output logic             o_coin_one,
    output logic             o_coin_two,
    output logic             o_coin_five,
    input  logic             i_hopper_ack,
    output logic             o_done,
    output logic             o_err,
    input  logic             i_refill,
    input  logic [1:0]       i_refill_sel,
    input  logic [CNT_W-1:0] i_refill_cnt,
    output logic [CNT_W-1:0] o_stock_one,
    output logic [CNT_W-1:0] o_stock_two,
    output logic [CNT_W-1:0] o_stock_five
);
    import vending_pkg::*;

    disp_state_t      r_state;
    disp_state_t      w_state_nxt;
    logic [AMT_W-1:0] r_amount;
    logic [AMT_W-1:0] r_n5;
    logic [AMT_W-1:0] r_n2;
    logic [AMT_W-1:0] r_n1;
    logic [CNT_W-1:0] r_stock_one;
    logic [CNT_W-1:0] r_stock_two;
    logic [CNT_W-1:0] r_stock_five;

    logic [AMT_W-1:0] w_plan_n5;
    logic [AMT_W-1:0] w_plan_n2;
    logic [AMT_W-1:0] w_plan_n1;
    logic             w_feasible;
    logic             w_latch_plan;
    logic [2:0]       w_coin_pick;
    logic [2:0]       w_take;
    logic             w_plan_last;
    logic             w_refill_en;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    change_planner #(
        .AMT_W(AMT_W),
        .CNT_W(CNT_W)
    ) u_planner (
        .i_amount    (r_amount),
        .i_stock_one (r_stock_one),
        .i_stock_two (r_stock_two),
        .i_stock_five(r_stock_five),
        .o_n5        (w_plan_n5),
        .o_n2        (w_plan_n2),
        .o_n1        (w_plan_n1),
        .o_feasible  (w_feasible)
    );

    // Highest denomination still owed; {five, two, one}.
    always_comb begin
        w_coin_pick = 3'b000;
        if (r_n5 != '0)      w_coin_pick = 3'b100;
        else if (r_n2 != '0) w_coin_pick = 3'b010;
        else if (r_n1 != '0) w_coin_pick = 3'b001;
    end

    // Total coins never exceed the amount, so the sum cannot wrap.
    assign w_plan_last = ((r_n5 + r_n2 + r_n1) == AMT_W'(1));
    assign w_take      = (r_state == ST_ISSUE && i_hopper_ack) ? w_coin_pick : 3'b000;
    assign w_refill_en = (r_state == ST_IDLE) && i_refill;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_amount <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && i_req) r_amount <= i_amount;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_latch_plan = 1'b0;
        o_busy       = (r_state != ST_IDLE);
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_coin_five  = 1'b0;
        o_coin_two   = 1'b0;
        o_coin_one   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (!w_feasible) begin
                    w_state_nxt = ST_ERR;
                end else if (r_amount == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt  = ST_ISSUE;
                    w_latch_plan = 1'b1;
                end
            end
            ST_ISSUE: begin
                {o_coin_five, o_coin_two, o_coin_one} = w_coin_pick;
                if (i_hopper_ack) w_state_nxt = w_plan_last ? ST_DONE : ST_GAP;
            end
            ST_GAP:  w_state_nxt = ST_ISSUE;
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                o_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_n5 <= '0;
            r_n2 <= '0;
            r_n1 <= '0;
        end else if (w_latch_plan) begin
            r_n5 <= w_plan_n5;
            r_n2 <= w_plan_n2;
            r_n1 <= w_plan_n1;
        end else begin
            r_n5 <= r_n5 - AMT_W'(w_take[2]);
            r_n2 <= r_n2 - AMT_W'(w_take[1]);
            r_n1 <= r_n1 - AMT_W'(w_take[0]);
        end
    end

    // Refill and dispense never coincide: one is IDLE-only, the other ISSUE-only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stock_one  <= INIT_ONE;
            r_stock_two  <= INIT_TWO;
            r_stock_five <= INIT_FIVE;
        end else if (w_refill_en) begin
            case (i_refill_sel)
                REFILL_ONE:  r_stock_one  <= sat_add(r_stock_one, i_refill_cnt);
                REFILL_TWO:  r_stock_two  <= sat_add(r_stock_two, i_refill_cnt);
                REFILL_FIVE: r_stock_five <= sat_add(r_stock_five, i_refill_cnt);
                default: ;
            endcase
        end else begin
            r_stock_five <= r_stock_five - CNT_W'(w_take[2]);
            r_stock_two  <= r_stock_two - CNT_W'(w_take[1]);
            r_stock_one  <= r_stock_one - CNT_W'(w_take[0]);
        end
    end

    assign o_stock_one  = r_stock_one;
    assign o_stock_two  = r_stock_two;
    assign o_stock_five = r_stock_five;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// transactions compared against a greedy coin-count model with stock tracking.
module tb_change_dispenser;

    localparam int AMT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_req = 1'b0;
    logic [AMT_W-1:0] i_amount = '0;
    logic             o_busy;
    logic             o_coin_one, o_coin_two, o_coin_five;
    logic             i_hopper_ack = 1'b0;
    logic             o_done, o_err;
    logic             i_refill = 1'b0;
    logic [1:0]       i_refill_sel = '0;
    logic [CNT_W-1:0] i_refill_cnt = '0;
    logic [CNT_W-1:0] o_stock_one, o_stock_two, o_stock_five;

    int checks = 0;
    int failures = 0;

    int m1, m2, m5;
    int exp_q[$];
    int got_q[$];
    bit got_done, got_err, exp_feas;
    int end_k, dly_sum;

    change_dispenser #(
        .AMT_W(AMT_W), .CNT_W(CNT_W),
        .INIT_ONE(8'd8), .INIT_TWO(8'd8), .INIT_FIVE(8'd8)
    ) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_amount(i_amount),
        .o_busy(o_busy), .o_coin_one(o_coin_one), .o_coin_two(o_coin_two),
        .o_coin_five(o_coin_five), .i_hopper_ack(i_hopper_ack),
        .o_done(o_done), .o_err(o_err), .i_refill(i_refill),
        .i_refill_sel(i_refill_sel), .i_refill_cnt(i_refill_cnt),
        .o_stock_one(o_stock_one), .o_stock_two(o_stock_two),
        .o_stock_five(o_stock_five)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; i_req = 1'b0; i_hopper_ack = 1'b0; i_refill = 1'b0;
        step();
        step();
        rst = 1'b1;
        m1 = 8; m2 = 8; m5 = 8;
    endtask

    task automatic model_refill(input int sel, input int cnt);
        case (sel)
            0: m1 = (m1 + cnt > 255) ? 255 : m1 + cnt;
            1: m2 = (m2 + cnt > 255) ? 255 : m2 + cnt;
            2: m5 = (m5 + cnt > 255) ? 255 : m5 + cnt;
            default: ;
        endcase
    endtask

    // Pay out largest coins while they fit and are in stock; ones cover the rest.
    task automatic model_plan(input int amt, output bit feas);
        int a, t5, t2;
        a = amt; t5 = m5; t2 = m2;
        exp_q.delete();
        while (a >= 5 && t5 > 0) begin exp_q.push_back(5); a -= 5; t5--; end
        while (a >= 2 && t2 > 0) begin exp_q.push_back(2); a -= 2; t2--; end
        feas = (a <= m1);
        if (!feas) exp_q.delete();
        else repeat (a) exp_q.push_back(1);
    endtask

    task automatic run_txn(input int amt, input int fix_dly, input int max_dly,
                           input int spur, input bit noise,
                           input bit rf, input int rsel, input int rcnt);
        int k, held, cur_dly, n, exp_end;
        logic [2:0] coins, cur_coin;
        bit acked_prev, seq_ok;
        if (rf) model_refill(rsel, rcnt);
        model_plan(amt, exp_feas);
        i_req = 1'b1; i_amount = AMT_W'(amt);
        i_refill = rf; i_refill_sel = 2'(rsel); i_refill_cnt = CNT_W'(rcnt);
        step();
        i_req = 1'b0; i_refill = 1'b0;
        k = 1; held = 0; acked_prev = 0; cur_coin = 3'b000;
        got_q.delete(); got_done = 0; got_err = 0; end_k = -1; dly_sum = 0;
        cur_dly = (fix_dly >= 0) ? fix_dly : $urandom_range(0, max_dly);
        while (k < 300) begin
            coins = {o_coin_five, o_coin_two, o_coin_one};
            checks++;
            if (o_stock_one !== CNT_W'(m1) || o_stock_two !== CNT_W'(m2) ||
                o_stock_five !== CNT_W'(m5)) begin
                failures++;
                $display("FAIL stock_track k=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", k,
                         o_stock_one, o_stock_two, o_stock_five, m1, m2, m5);
            end
            checks++;
            if ($countones(coins) > 1 || (acked_prev && coins != 3'b000) ||
                o_busy !== 1'b1) begin
                failures++;
                $display("FAIL coin_protocol k=%0d coins=%b busy=%b after_ack=%0d",
                         k, coins, o_busy, acked_prev);
            end
            if (o_done || o_err) begin
                got_done = o_done; got_err = o_err; end_k = k;
                break;
            end
            i_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            i_refill = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            i_refill_sel = 2'($urandom_range(0, 3));
            i_refill_cnt = CNT_W'($urandom_range(1, 40));
            acked_prev = 0;
            if (coins != 3'b000) begin
                if (held == 0) cur_coin = coins;
                else if (coins != cur_coin) begin
                    failures++;
                    $display("FAIL coin_held k=%0d got=%b want=%b", k, coins, cur_coin);
                end
                checks++;
                if (held == cur_dly) begin
                    i_hopper_ack = 1'b1;
                    case (coins)
                        3'b100: begin got_q.push_back(5); m5--; end
                        3'b010: begin got_q.push_back(2); m2--; end
                        default: begin got_q.push_back(1); m1--; end
                    endcase
                    dly_sum += cur_dly; held = 0; acked_prev = 1;
                    cur_dly = (fix_dly >= 0) ? fix_dly : $urandom_range(0, max_dly);
                end else begin
                    i_hopper_ack = 1'b0;
                    held++;
                end
            end else begin
                i_hopper_ack = (spur == 2) ? 1'b1 :
                               (spur == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            step();
            k++;
        end
        i_req = 1'b0; i_refill = 1'b0; i_hopper_ack = 1'b0;
        checks++;
        if (end_k < 0) begin
            failures++;
            $display("FAIL txn_timeout amt=%0d no done/err within budget", amt);
        end
        n = exp_q.size();
        exp_end = !exp_feas ? 2 : (n == 0 ? 2 : 1 + dly_sum + 2 * n);
        checks++;
        if (got_done !== exp_feas || got_err !== !exp_feas || end_k !== exp_end) begin
            failures++;
            $display("FAIL txn_outcome amt=%0d done=%0d err=%0d end=%0d want done=%0d err=%0d end=%0d",
                     amt, got_done, got_err, end_k, exp_feas, !exp_feas, exp_end);
        end
        seq_ok = (got_q.size() == exp_q.size());
        if (seq_ok) foreach (got_q[i]) if (got_q[i] != exp_q[i]) seq_ok = 0;
        checks++;
        if (!seq_ok) begin
            failures++;
            $display("FAIL coin_sequence amt=%0d got=%p want=%p", amt, got_q, exp_q);
        end
        step();
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0 ||
            o_stock_one !== CNT_W'(m1) || o_stock_two !== CNT_W'(m2) ||
            o_stock_five !== CNT_W'(m5)) begin
            failures++;
            $display("FAIL post_txn amt=%0d busy=%b done=%b err=%b stock=%0d/%0d/%0d want 0/0/0 %0d/%0d/%0d",
                     amt, o_busy, o_done, o_err, o_stock_one, o_stock_two, o_stock_five, m1, m2, m5);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_busy, o_coin_five, o_coin_two, o_coin_one, o_done, o_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {o_busy, o_coin_five, o_coin_two, o_coin_one, o_done, o_err});
        end
        checks++;
        if (o_stock_one !== 8'd8 || o_stock_two !== 8'd8 || o_stock_five !== 8'd8) begin
            failures++;
            $display("FAIL reset_stock got=%0d/%0d/%0d want=8/8/8",
                     o_stock_one, o_stock_two, o_stock_five);
        end
    endtask

    task automatic test_eight_tied_ack();
        do_reset();
        run_txn(8, 0, 0, 2, 0, 0, 0, 0);
        checks++;
        if (end_k !== 7 || o_stock_one !== 8'd7 || o_stock_two !== 8'd7 ||
            o_stock_five !== 8'd7) begin
            failures++;
            $display("FAIL eight_tied end=%0d stock=%0d/%0d/%0d want end=7 stock=7/7/7",
                     end_k, o_stock_one, o_stock_two, o_stock_five);
        end
    endtask

    task automatic test_ack_withheld();
        do_reset();
        run_txn(5, 3, 0, 0, 0, 0, 0, 0);
        checks++;
        if (end_k !== 6 || o_stock_five !== 8'd7) begin
            failures++;
            $display("FAIL ack_withheld_five end=%0d stock5=%0d want end=6 stock5=7",
                     end_k, o_stock_five);
        end
        run_txn(7, 3, 0, 2, 0, 0, 0, 0);
        checks++;
        if (end_k !== 11 || o_stock_five !== 8'd6 || o_stock_two !== 8'd7) begin
            failures++;
            $display("FAIL ack_gap_spurious end=%0d stock5=%0d stock2=%0d want 11 6 7",
                     end_k, o_stock_five, o_stock_two);
        end
    endtask

    task automatic test_no_twos_and_err();
        do_reset();
        repeat (4) run_txn(4, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o_stock_two !== 8'd0) begin
            failures++;
            $display("FAIL drain_twos got=%0d want=0", o_stock_two);
        end
        run_txn(4, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (got_q.size() != 4 || o_stock_one !== 8'd4) begin
            failures++;
            $display("FAIL no_twos coins=%0d stock1=%0d want coins=4 stock1=4",
                     got_q.size(), o_stock_one);
        end
        run_txn(4, 1, 0, 1, 1, 0, 0, 0);
        run_txn(6, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (got_err !== 1'b1 || end_k !== 2 || got_q.size() != 0 ||
            o_stock_five !== 8'd8 || o_stock_one !== 8'd0) begin
            failures++;
            $display("FAIL greedy_err err=%0d end=%0d coins=%0d s5=%0d s1=%0d want 1 2 0 8 0",
                     got_err, end_k, got_q.size(), o_stock_five, o_stock_one);
        end
    endtask

    task automatic test_zero();
        do_reset();
        run_txn(0, 0, 0, 2, 0, 0, 0, 0);
        checks++;
        if (got_done !== 1'b1 || end_k !== 2 || got_q.size() != 0) begin
            failures++;
            $display("FAIL zero_amount done=%0d end=%0d coins=%0d want 1 2 0",
                     got_done, end_k, got_q.size());
        end
    endtask

    task automatic test_refill();
        do_reset();
        i_refill = 1'b1; i_refill_sel = 2'd0; i_refill_cnt = 8'd250;
        step();
        model_refill(0, 250);
        i_refill = 1'b1; i_refill_sel = 2'd3; i_refill_cnt = 8'd10;
        step();
        i_refill = 1'b0;
        checks++;
        if (o_stock_one !== 8'd255 || o_stock_two !== 8'd8 || o_stock_five !== 8'd8) begin
            failures++;
            $display("FAIL refill_sat got=%0d/%0d/%0d want=255/8/8",
                     o_stock_one, o_stock_two, o_stock_five);
        end
        // Refill alongside the request: planner must see 8+3 fives.
        run_txn(15, 0, 0, 0, 0, 1, 2, 3);
        checks++;
        if (o_stock_five !== 8'd8 || got_q.size() != 3) begin
            failures++;
            $display("FAIL refill_with_req s5=%0d coins=%0d want s5=8 coins=3",
                     o_stock_five, got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_req = 1'b1; i_amount = 4'd8;
        step();
        i_req = 1'b0;
        step();
        i_hopper_ack = 1'b1;
        step();
        i_hopper_ack = 1'b0;
        step();
        checks++;
        if (o_coin_two !== 1'b1 || o_stock_five !== 8'd7) begin
            failures++;
            $display("FAIL mid_issue coin2=%b s5=%0d want 1 7", o_coin_two, o_stock_five);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({o_busy, o_coin_five, o_coin_two, o_coin_one, o_done, o_err} !== 6'b0 ||
            o_stock_one !== 8'd8 || o_stock_two !== 8'd8 || o_stock_five !== 8'd8) begin
            failures++;
            $display("FAIL reset_mid outs=%b stock=%0d/%0d/%0d want 000000 8/8/8",
                     {o_busy, o_coin_five, o_coin_two, o_coin_one, o_done, o_err},
                     o_stock_one, o_stock_two, o_stock_five);
        end
        rst = 1'b1;
        step();
        checks++;
        if (o_busy !== 1'b0 || o_coin_two !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle busy=%b coin2=%b want 0 0", o_busy, o_coin_two);
        end
        m1 = 8; m2 = 8; m5 = 8;
    endtask

    task automatic test_random();
        int amt, sel, cnt;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            amt = $urandom_range(0, 15);
            sel = $urandom_range(0, 3);
            cnt = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) begin
                i_refill = 1'b1; i_refill_sel = 2'(sel); i_refill_cnt = CNT_W'(cnt);
                step();
                i_refill = 1'b0;
                model_refill(sel, cnt);
                checks++;
                if (o_stock_one !== CNT_W'(m1) || o_stock_two !== CNT_W'(m2) ||
                    o_stock_five !== CNT_W'(m5)) begin
                    failures++;
                    $display("FAIL idle_refill sel=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", sel,
                             o_stock_one, o_stock_two, o_stock_five, m1, m2, m5);
                end
            end
            run_txn(amt, -1, 2, 1, 1, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_eight_tied_ack();
        test_ack_withheld();
        test_no_twos_and_err();
        test_zero();
        test_refill();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
